// File: rtl/game_table_lcd_scanner.sv
// Renders the 10x10 game table into a page-organised 64x64 monochrome LCD frame
// and streams it one byte per beat over valid/ready, from a snapshot taken at frame start.
module game_table_lcd_scanner #(
  parameter int CELL_PX   = 6,
  parameter int GRID      = 10,
  parameter int LCD_PAGES = 8,
  parameter int LCD_COLS  = 64
) (
  input  logic                 clk_40M,
  input  logic                 rst,
  input  logic [GRID*GRID-1:0] game_table,
  input  logic                 frame_req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_page,
  output logic [6:0]           out_col,
  output logic [7:0]           out_data,
  output logic                 frame_busy,
  output logic                 frame_done
);
  localparam int CS_W = $clog2(CELL_PX);
  localparam int CX_W = $clog2(GRID + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
  state_t state, state_nxt;

  logic [GRID*GRID-1:0]         snap;
  logic [2:0]                   pg;   // next beat to load into the output register
  logic [6:0]                   cl;
  logic [CX_W-1:0]              cx;   // cl / CELL_PX, saturates at GRID in the blank margin
  logic [CS_W-1:0]              cs;   // cl % CELL_PX
  logic [GRID-1:0]              col_bits;
  logic [LCD_PAGES-1:0][7:0]    byte_lut;
  logic [7:0]                   pix_byte;
  logic                         accept, last;

  assign accept     = out_valid && out_ready;
  assign last       = (out_page == 3'(LCD_PAGES-1)) && (out_col == 7'(LCD_COLS-1));
  assign frame_busy = (state != IDLE);

  // One bit per cell row for the current cell column; blank columns never index snap.
  always_comb begin
    col_bits = '0;
    if (cx < CX_W'(GRID))
      for (int r = 0; r < GRID; r++) col_bits[r] = snap[r*GRID + int'(cx)];
  end

  // Pixel row -> cell row is a constant per (page, bit), so no divider is needed.
  for (genvar p = 0; p < LCD_PAGES; p++) begin : g_page
    for (genvar k = 0; k < 8; k++) begin : g_bit
      localparam int Y = p*8 + k;
      if (Y < GRID*CELL_PX) begin : g_on
        assign byte_lut[p][k] = col_bits[Y/CELL_PX];
      end else begin : g_off
        assign byte_lut[p][k] = 1'b0;
      end
    end
  end
  assign pix_byte = byte_lut[pg];

  always_ff @(posedge clk_40M or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_req) state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (accept && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      snap       <= '0;
      pg         <= '0;
      cl         <= '0;
      cx         <= '0;
      cs         <= '0;
      out_valid  <= 1'b0;
      out_page   <= '0;
      out_col    <= '0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == SEND) && accept && last;
      case (state)
        LOAD: begin
          snap      <= game_table;
          pg        <= '0;
          cl        <= '0;
          cx        <= '0;
          cs        <= '0;
          out_valid <= 1'b0;
        end
        SEND: begin
          if (accept && last) begin
            out_valid <= 1'b0;
          end else if (!out_valid || accept) begin
            out_valid <= 1'b1;
            out_page  <= pg;
            out_col   <= cl;
            out_data  <= pix_byte;
            if (cl == 7'(LCD_COLS-1)) begin
              cl <= '0;
              pg <= pg + 3'd1;
              cx <= '0;
              cs <= '0;
            end else begin
              cl <= cl + 7'd1;
              if (cs == CS_W'(CELL_PX-1)) begin
                cs <= '0;
                cx <= cx + CX_W'(1);
              end else begin
                cs <= cs + CS_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_game_table_lcd_scanner.sv
// Randomised bench for game_table_lcd_scanner against a pixel-rule reference model.
module tb_game_table_lcd_scanner;
  localparam int CELL = 6;
  localparam int GRD  = 10;

  logic        clk_40M = 0;
  logic        rst;
  logic [99:0] game_table;
  logic        frame_req;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_page;
  logic [6:0]  out_col;
  logic [7:0]  out_data;
  logic        frame_busy;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  game_table_lcd_scanner dut (
    .clk_40M(clk_40M), .rst(rst), .game_table(game_table), .frame_req(frame_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_page(out_page), .out_col(out_col),
    .out_data(out_data), .frame_busy(frame_busy), .frame_done(frame_done)
  );

  always #12 clk_40M = ~clk_40M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [99:0] t, input int pg, input int col);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      int y;
      y = pg*8 + k;
      if (col < GRD*CELL && y < GRD*CELL) b[k] = t[(y/CELL)*GRD + col/CELL];
    end
    return b;
  endfunction

  function automatic logic [99:0] rand_tbl();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[99:0];
  endfunction

  // rdy_mode 0: ready always high; 1: random ready. chg_at/rst_at < 0 disables that event.
  task automatic run_frame(input logic [99:0] tbl, input int rdy_mode, input int chg_at, input int rst_at);
    int n, beat, first_v, done_n;
    logic stalled;
    logic [17:0] held;
    game_table = tbl;
    frame_req  = 1;
    @(posedge clk_40M); #1;
    frame_req = 0;
    n = 0; beat = 0; first_v = -1; done_n = -1; stalled = 0; held = '0;
    chk("busy_load", frame_busy, 1);
    while (done_n < 0 && n < 6000) begin
      @(posedge clk_40M); #1;
      n++;
      if (stalled) chk("stall", {out_valid, out_page, out_col, out_data}, {1'b1, held});
      if (out_valid && first_v < 0) begin
        first_v = n;
        chk("first_lat", n, 2);
      end
      if (frame_done) begin
        done_n = n;
        chk("done_beats", beat, 512);
        chk("valid_drop", out_valid, 0);
        if (rdy_mode == 0) chk("done_lat", n + 1, 515);
        break;
      end
      if (rst_at >= 0 && beat == rst_at) begin
        rst = 1;
        @(posedge clk_40M); #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", frame_busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_addr", {out_page, out_col}, 0);
        rst = 0;
        out_ready = 1;
        return;
      end
      if (chg_at >= 0 && beat == chg_at) begin
        game_table = ~tbl ^ rand_tbl();
        frame_req  = 1;
      end else begin
        frame_req = 0;
      end
      out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      stalled = 0;
      if (out_valid) begin
        if (out_ready) begin
          chk("beat", {out_page, out_col, out_data},
              {3'(beat/64), 7'(beat%64), model_byte(tbl, beat/64, beat%64)});
          beat++;
        end else begin
          stalled = 1;
          held = {out_page, out_col, out_data};
        end
      end
    end
    if (done_n < 0) chk("timeout", 1, 0);
    frame_req = 0;
    @(posedge clk_40M); #1;
    chk("done_pulse", frame_done, 0);
    chk("idle_busy", frame_busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_40M); #1;
      chk("no_restart", {out_valid, frame_busy}, 0);
    end
  endtask

  initial begin
    logic [99:0] t;
    rst = 1; game_table = '0; frame_req = 0; out_ready = 1;
    repeat (3) @(posedge clk_40M);
    #1;
    chk("rst_state", {out_valid, out_page, out_col, out_data, frame_busy, frame_done}, 0);
    rst = 0;
    repeat (2) @(posedge clk_40M);
    #1;
    chk("idle_hold", {out_valid, frame_busy}, 0);

    t = '0; t[0]  = 1'b1; run_frame(t, 0, -1, -1);
    t = '0; t[10] = 1'b1; run_frame(t, 0, -1, -1);
    t = '0; t[99] = 1'b1; run_frame(t, 0, -1, -1);
    t = '1;               run_frame(t, 1, -1, -1);
    run_frame(rand_tbl(), 0, 100, -1);
    run_frame(rand_tbl(), 1, 100, -1);
    run_frame(rand_tbl(), 1, -1, 300);
    repeat (2) @(posedge clk_40M);
    #1;
    run_frame(rand_tbl(), 0, -1, -1);
    run_frame(rand_tbl(), 1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
